// File: rtl/dsp_pkg.sv
// Shared encodings and default widths for the wavetable address/crossfade pipeline.
package dsp_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_FRAC_W = 8;
  localparam int unsigned DEF_STEP_W = 16;
  localparam int unsigned DEF_LEN_W  = 16;

  typedef enum logic [1:0] {
    MODE_STEADY = 2'b00,
    MODE_RISE   = 2'b01,
    MODE_FALL   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/step_glide.sv
// Combinational next phase step: steady hold, or saturating glide toward the limit.
module step_glide
  import dsp_pkg::*;
#(
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  mode_t             i_mode,
  input  logic [STEP_W-1:0] i_step,
  input  logic [STEP_W-1:0] i_delta,
  input  logic [STEP_W-1:0] i_limit,
  output logic [STEP_W-1:0] o_step_next
);

  logic [STEP_W:0] w_sum;
  logic [STEP_W:0] w_diff;

  // One guard bit: overflow of the add / borrow of the subtract saturates to the limit.
  assign w_sum  = {1'b0, i_step} + {1'b0, i_delta};
  assign w_diff = {1'b0, i_step} - {1'b0, i_delta};

  always_comb begin
    o_step_next = i_step;
    case (i_mode)
      MODE_RISE: o_step_next = (w_sum > {1'b0, i_limit}) ? i_limit : w_sum[STEP_W-1:0];
      MODE_FALL: o_step_next = (w_diff[STEP_W] || (w_diff < {1'b0, i_limit}))
                               ? i_limit : w_diff[STEP_W-1:0];
      default:   o_step_next = i_step;
    endcase
  end

endmodule

// File: rtl/wavetable_sequencer.sv
// Phase-accumulator wavetable walker: emits adjacent address pairs and crossfade weights
// over a valid/ready stream for a programmed number of samples.
module wavetable_sequencer
  import dsp_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned STEP_W = DEF_STEP_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step_init,
  input  logic [STEP_W-1:0] step_delta,
  input  logic [STEP_W-1:0] step_limit,
  input  logic [LEN_W-1:0]  length,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [FRAC_W:0]   w0,
  output logic [FRAC_W:0]   w1,
  output logic              smooth,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     PH_W   = ADDR_W + FRAC_W;
  localparam logic [FRAC_W:0] W_FULL = {1'b1, {FRAC_W{1'b0}}};

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [STEP_W-1:0] r_step;
  logic [LEN_W-1:0]  r_count;
  mode_t             r_mode;
  logic [STEP_W-1:0] r_delta;
  logic [STEP_W-1:0] r_limit;

  logic              w_accept;
  logic [PH_W-1:0]   w_phase_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [FRAC_W-1:0] w_frac_next;
  logic [STEP_W-1:0] w_step_next;

  assign w_accept     = out_valid && out_ready;
  assign w_phase_next = r_phase + PH_W'(r_step);
  assign w_addr_next  = w_phase_next[PH_W-1:FRAC_W];
  assign w_frac_next  = w_phase_next[FRAC_W-1:0];
  assign busy         = (r_state != IDLE);

  step_glide #(
    .STEP_W(STEP_W)
  ) u_glide (
    .i_mode     (r_mode),
    .i_step     (r_step),
    .i_delta    (r_delta),
    .i_limit    (r_limit),
    .o_step_next(w_step_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_step    <= '0;
      r_count   <= '0;
      r_mode    <= MODE_STEADY;
      r_delta   <= '0;
      r_limit   <= '0;
      out_valid <= 1'b0;
      addr0     <= '0;
      addr1     <= '0;
      w0        <= W_FULL;
      w1        <= '0;
      smooth    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_phase <= '0;
            r_step  <= step_init;
            r_count <= length;
            r_mode  <= mode_t'(mode);
            r_delta <= step_delta;
            r_limit <= step_limit;
            addr0   <= '0;
            addr1   <= ADDR_W'(1);
            w0      <= W_FULL;
            w1      <= '0;
            smooth  <= 1'b0;
            if (length != '0) begin
              r_state   <= RUN;
              out_valid <= 1'b1;
            end else begin
              r_state <= DONE;
              done    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
          end else if (w_accept) begin
            // Fields for the following sample come straight from the next phase.
            r_phase <= w_phase_next;
            r_step  <= w_step_next;
            r_count <= r_count - LEN_W'(1);
            addr0   <= w_addr_next;
            addr1   <= w_addr_next + ADDR_W'(1);
            w1      <= {1'b0, w_frac_next};
            w0      <= W_FULL - {1'b0, w_frac_next};
            smooth  <= |w_frac_next;
            if (r_count == LEN_W'(1)) begin
              out_valid <= 1'b0;
              r_state   <= DONE;
              done      <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
